// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the 7-segment display path.
//   SEG_0..SEG_9, SEG_OFF : segment patterns, bit order {a,b,c,d,e,f,g},
//                           active-high
//   state_t               : scanner states (BLANK, DRIVE)
//   bcd_to_seg()          : nibble to segment pattern; 10..15 decode to off
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD nibble to 7-segment decoder. It is also used by the
// single-digit counter display.
// Ports:
//   bcd : in  [3:0]  BCD digit (10..15 decode to all segments off)
//   seg : out [6:0]  {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg7_digit_scanner.sv
// -----------------------------------------------------------------------------
// seg7_digit_scanner
// Time-multiplexes a packed BCD word onto a common-segment multi-digit
// 7-segment display. A loaded value is held in a pending register and is
// committed to the displayed shadow only at a frame boundary, so one frame
// never mixes two values. An all-off blanking gap between digit slots
// suppresses ghosting.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digits above the highest nonzero shadow nibble are
//   suppressed (seg off, dig_en off) during their slot. Digit 0 is always
//   shown. Slot timing is unchanged.
//
// Parameters:
//   NUM_DIGITS       number of digits scanned (>=1)
//   REFRESH_DIV      clk cycles each digit is driven (>=1)
//   BLANK_CYCLES     clk cycles of all-off between digits (0 removes the gap)
//   ACTIVE_LOW_DIGIT 1 inverts dig_en (off = all ones)
// Ports:
//   clk         : in   system clock
//   rst         : in   synchronous reset, active-high
//   load        : in   strobe, capture bcd_in this cycle
//   bcd_in      : in   packed BCD, nibble k = digit k (digit 0 = LSD)
//   seg         : out  {a,b,c,d,e,f,g}, active-high, registered
//   dig_en      : out  one-hot digit enable, registered
//   frame_start : out  1-cycle pulse when the scan enters digit 0
//
// state | meaning
// BLANK | all digits off for BLANK_CYCLES cycles before the next slot
// DRIVE | digit idx on, showing shadow[idx], for REFRESH_DIV cycles
// -----------------------------------------------------------------------------
module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 27000,
    parameter int BLANK_CYCLES     = 270,
    parameter int ACTIVE_LOW_DIGIT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_start
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW      = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam state_t           SLOT_ENTRY = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW_DIGIT != 0) ? '1 : '0;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]           shadow_q, shadow_d;
    logic [BW-1:0]           pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic                    first_q, first_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic [3:0]              nib_sel;
    logic [6:0]              seg_dec;
    logic                    digit_shown;
    logic [NUM_DIGITS-1:0]   dig_onehot;

    // Scan sequencing. The first edge out of reset is treated exactly like
    // an index wrap, so the very first frame has the same period and
    // frame_start placement as every later frame.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_W'(1);
        first_d  = 1'b0;
        boundary = 1'b0;

        if (first_q) begin
            state_d  = SLOT_ENTRY;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b1;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = SLOT_ENTRY;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Load handling: a load landing on the boundary edge goes straight to
    // the shadow; otherwise it parks in pending (latest wins) until the
    // next boundary.
    always_comb begin
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;

        if (boundary) begin
            if (load) begin
                shadow_d        = bcd_in;
                pending_valid_d = 1'b0;
            end else if (pending_valid_q) begin
                shadow_d        = pending_q;
                pending_valid_d = 1'b0;
            end
        end else if (load) begin
            pending_d       = bcd_in;
            pending_valid_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they describe the
    // state being entered on the same edge.
    always_comb begin
        nib_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                nib_sel = shadow_d[4*k +: 4];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (nib_sel),
        .seg (seg_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] top_nz;

    always_comb begin
        top_nz = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shadow_d[4*k +: 4] != 4'd0) begin
                top_nz = IDX_W'(k);
            end
        end
        digit_shown = (idx_d <= top_nz);
    end
`else
    always_comb begin
        digit_shown = 1'b1;
    end
`endif

    always_comb begin
        dig_onehot    = NUM_DIGITS'(1) << idx_d;
        seg_d         = SEG_OFF;
        dig_en_d      = DIG_OFF;
        frame_start_d = boundary;
        if (state_d == DRIVE && digit_shown) begin
            seg_d    = seg_dec;
            dig_en_d = (ACTIVE_LOW_DIGIT != 0) ? ~dig_onehot : dig_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= BLANK;
            idx_q           <= '0;
            cnt_q           <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            first_q         <= 1'b1;
            seg_q           <= SEG_OFF;
            dig_en_q        <= DIG_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            first_q         <= first_d;
            seg_q           <= seg_d;
            dig_en_q        <= dig_en_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dig_en      = dig_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
module tb_seg7_digit_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seg7_digit_scanner #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (4),
        .BLANK_CYCLES     (2),
        .ACTIVE_LOW_DIGIT (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bcd_in      (bcd_in),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Called at the falling edge of the frame_start cycle. Each frame is
    // 4 slots of 6 cycles: 2 blank then 4 driven. Optional loads are held
    // high through cycle ld*_c, i.e. sampled on the edge ending that cycle.
    task automatic run_frame(input string name, input logic [15:0] shown,
                             input int ld1_c, input logic [15:0] ld1_v,
                             input int ld2_c, input logic [15:0] ld2_v,
                             input int ncyc);
        int         hi;
        int         slot;
        int         off;
        logic [15:0] val;
        logic [3:0]  nib;
        logic [6:0]  e_seg;
        logic [3:0]  e_dig;
        val = shown;
        hi  = 3;
`ifdef LEADING_ZERO_BLANK_EN
        hi = 0;
        for (int k = 1; k < 4; k++) if (val[4*k +: 4] != 4'd0) hi = k;
`endif
        for (int c = 0; c < ncyc; c++) begin
            slot = c / 6;
            off  = c % 6;
            nib  = val[4*slot +: 4];
            if (off < 2 || slot > hi) begin
                e_seg = 7'd0;
                e_dig = 4'd0;
            end else begin
                e_seg = exp_seg(nib);
                e_dig = 4'd1 << slot;
            end
            check($sformatf("%s c%0d seg", name, c), 32'(seg), 32'(e_seg));
            check($sformatf("%s c%0d dig_en", name, c), 32'(dig_en), 32'(e_dig));
            check($sformatf("%s c%0d frame_start", name, c), 32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
            if (c == ld1_c) begin
                load   = 1'b1;
                bcd_in = ld1_v;
            end else if (c == ld2_c) begin
                load   = 1'b1;
                bcd_in = ld2_v;
            end
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 16'h0;
        repeat (3) @(negedge clk);
        check("reset seg", 32'(seg), 32'd0);
        check("reset dig_en", 32'(dig_en), 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);

        rst = 1'b0;
        @(negedge clk);

        run_frame("f0_zero", 16'h0000, -1, 16'h0, -1, 16'h0, 24);
        run_frame("f1_load1234", 16'h0000, 15, 16'h1234, -1, 16'h0, 24);
        run_frame("f2_1234", 16'h1234, 3, 16'h1111, 10, 16'h5678, 24);
        run_frame("f3_5678", 16'h5678, 23, 16'h00A0, -1, 16'h0, 24);
        run_frame("f4_00A0", 16'h00A0, -1, 16'h0, -1, 16'h0, 24);

        // reset mid-drive of digit 2 with a load pending
        run_frame("f5_partial", 16'h00A0, 5, 16'h9999, -1, 16'h0, 16);
        rst = 1'b1;
        @(negedge clk);
        check("midrst seg", 32'(seg), 32'd0);
        check("midrst dig_en", 32'(dig_en), 32'd0);
        check("midrst frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_frame("f6_after_rst", 16'h0000, -1, 16'h0, -1, 16'h0, 24);
        run_frame("f7_after_rst", 16'h0000, 10, 16'h0050, -1, 16'h0, 24);
        run_frame("f8_0050", 16'h0050, 10, 16'h0000, -1, 16'h0, 24);
        run_frame("f9_0000", 16'h0000, -1, 16'h0, -1, 16'h0, 24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_digit_scanner.md
Name: seg7_digit_scanner

Overview:
Downstream stage of the BCD counter/decoder path. It drives a common-segment multi-digit 7-segment display by time-multiplexing the digits. The block latches a packed BCD word through a load strobe and commits it only at frame boundaries, so the display never tears. It then scans the digits one at a time, with a blanking gap between digits to suppress ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
REFRESH_DIV, 27000, clk cycles each digit is driven (>=1); 1 kHz per digit at 27 MHz
BLANK_CYCLES, 270, clk cycles of all-off between digits (>=0; 0 removes the BLANK state)
ACTIVE_LOW_DIGIT, 0, 1 inverts dig_en polarity (off = all ones)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
load  in  1  strobe; capture bcd_in this cycle
bcd_in  in  4*NUM_DIGITS  packed BCD; nibble k = digit k, digit 0 rightmost/LSD
seg  out  7  {a,b,c,d,e,f,g}, active-high
dig_en  out  NUM_DIGITS  one-hot digit enable (polarity per ACTIVE_LOW_DIGIT)
frame_start  out  1  1-cycle pulse when the scan enters digit 0

Behaviour:
- All outputs are registered and update on the same edge as the state registers; they reflect the state entered at that edge.
- Reset values: state=BLANK, idx=0, cycle counter=0, shadow=0 (displays 0…0), pending_valid=0, seg=0, dig_en=off, frame_start=0.
- FSM:
  - BLANK: seg=0, dig_en=off for BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: dig_en one-hot at idx, seg=decode(shadow[idx]) for REFRESH_DIV cycles. Then go to BLANK, with idx=idx+1 and wrap from NUM_DIGITS-1 to 0.
  - If BLANK_CYCLES=0, DRIVE goes directly to the next DRIVE.
- Cycle counter: width $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1). It clears on every state change.
- Frame boundary: the edge where idx wraps to 0, plus the first edge out of reset.
  - frame_start pulses on that edge.
  - If pending_valid=1, then shadow<=pending and pending_valid<=0.
- Load handling:
  - load=1 writes pending<=bcd_in and sets pending_valid; the latest load wins.
  - load=1 on the frame-boundary edge bypasses pending: shadow<=bcd_in directly and pending_valid<=0.
- Decode table, nibble to seg:
  - 0 → 1111110
  - 1 → 0110000
  - 2 → 1101101
  - 3 → 1111001
  - 4 → 0110011
  - 5 → 1011011
  - 6 → 1011111
  - 7 → 1110000
  - 8 → 1111111
  - 9 → 1111011
  - 10–15 → 0000000; dig_en is still asserted for that digit.
- rst asserted in any state: the next edge applies the reset values; any in-flight pending is discarded.
- Frame period is NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the highest nonzero shadow nibble are suppressed during their DRIVE slot (seg=0, dig_en=off). Slot timing is unchanged. Digit 0 is always shown, so an all-zero value displays a single 0. Nibbles 10–15 count as nonzero.
- Undefined: every digit is always driven.

Decomposition:
- Package seg7_pkg holds:
  - SEG_0..SEG_9 and SEG_OFF 7-bit constants
  - state enum {BLANK, DRIVE}
  - function bcd_to_seg(input [3:0]) returning [6:0]
- Sub-module bcd_to_seg7: combinational nibble→seg, wrapping the package function. It is instanced once on shadow[idx], and is reused by the team's single-digit counter display.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, ACTIVE_LOW_DIGIT=0.
1. Reset release, no load → 2 cycles seg=0/dig_en=0000, then 4 cycles dig_en=0001 seg=1111110; digits 1,2,3 follow. frame_start repeats every 24 cycles.
2. load bcd_in=16'h1234 during digit-2 DRIVE → the current frame still shows 0000. Next frame: digit 0 seg=0110011 (4), digit 1 1111001 (3), digit 2 1101101 (2), digit 3 0110000 (1).
3. load 16'h1111 then load 16'h5678 within the same frame → the next frame shows 5678 and never shows 1111. A load on the frame-boundary edge takes effect in that same frame.
4. bcd_in=16'h00A0 → digit 1 slot has dig_en=0010 with seg=0000000; digits 0,2,3 show 0.
5. rst pulsed mid-DRIVE of digit 2 while a load is pending → next edge gives seg=0, dig_en=0000. The scan restarts at digit 0 showing 0000, and the pending value is lost.
6. LEADING_ZERO_BLANK_EN defined:
   - load 16'h0050 → digit 3 and digit 2 slots have dig_en=0000; digit 1 shows 1011011; digit 0 shows 1111110.
   - load 16'h0000 → only digit 0 is enabled.
